// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, registered PC redirect, wrong-path squash and EX/MEM register.
// Optional performance counters are enabled by defining EX_PERF_CNT_EN.
module ex_stage #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic [31:0] rs1Val,
  input  logic [31:0] rs2Val,
  input  logic        selA,
  input  logic [1:0]  selB,
  input  logic [3:0]  aluOp,
  input  logic [1:0]  memSize,
  input  logic [1:0]  memOp,
  input  logic [4:0]  rd,
  input  logic        aluToReg,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        memStall,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirectPc,
  output logic        exValid,
  output logic [31:0] exResult,
  output logic [31:0] exStoreData,
  output logic [1:0]  exMemSize,
  output logic [1:0]  exMemOp,
  output logic [4:0]  exRd,
`ifdef EX_PERF_CNT_EN
  output logic [31:0] perfOps,
  output logic [31:0] perfRedirects,
`endif
  output logic        exRegWrite
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT   = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA   = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_PASSB = 4'd10, ALU_EQ   = 4'd11,
    ALU_NE   = 4'd12, ALU_GE   = 4'd13, ALU_GEU  = 4'd14, ALU_ZERO  = 4'd15
  } alu_op_e;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  state_e      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic [31:0] op_a, op_b, alu_result, target;
  logic [4:0]  shamt;
  logic        consume, bubble, taken, squashing, issue_redirect, write_valid;

  assign stall     = memStall;
  assign consume   = ~memStall;
  assign bubble    = (memOp == 2'b00) & ~aluToReg & ~branch & ~jal & ~jalr;
  assign squashing = (state == SQUASH);

  assign op_a  = selA ? pc : rs1Val;
  assign shamt = op_b[4:0];

  always_comb begin
    op_b = 32'd0;
    case (selB)
      2'd0:    op_b = rs2Val;
      2'd1:    op_b = imm;
      2'd2:    op_b = 32'd4;
      default: op_b = 32'd0;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (alu_op_e'(aluOp))
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_SLL:   alu_result = op_a << shamt;
      ALU_SLT:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_result = {31'd0, op_a < op_b};
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_SRL:   alu_result = op_a >> shamt;
      ALU_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:    alu_result = op_a | op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_PASSB: alu_result = op_b;
      ALU_EQ:    alu_result = {31'd0, op_a == op_b};
      ALU_NE:    alu_result = {31'd0, op_a != op_b};
      ALU_GE:    alu_result = {31'd0, $signed(op_a) >= $signed(op_b)};
      ALU_GEU:   alu_result = {31'd0, op_a >= op_b};
      default:   alu_result = 32'd0;
    endcase
  end

  assign taken  = jal | jalr | (branch & alu_result[0]);
  assign target = jalr ? ((rs1Val + imm) & ~32'd1) : (pc + imm);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    issue_redirect = 1'b0;
    if (consume) begin
      case (state)
        RUN: begin
          if (taken) begin
            state_next     = SQUASH;
            cnt_next       = 3'(FLUSH_DEPTH);
            issue_redirect = 1'b1;
          end
        end
        SQUASH: begin
          cnt_next = cnt - 3'd1;
          if (cnt == 3'd1) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The pulse is cleared on stalled edges too, so a redirect lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect   <= 1'b0;
      redirectPc <= 32'd0;
    end else begin
      redirect <= issue_redirect;
      if (issue_redirect) redirectPc <= target;
    end
  end

  assign write_valid = ~squashing & ~bubble;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exValid     <= 1'b0;
      exResult    <= 32'd0;
      exStoreData <= 32'd0;
      exMemSize   <= 2'd0;
      exMemOp     <= 2'd0;
      exRd        <= 5'd0;
      exRegWrite  <= 1'b0;
    end else if (consume) begin
      exValid     <= write_valid;
      exResult    <= (jal | jalr) ? (pc + 32'd4) : alu_result;
      exStoreData <= rs2Val;
      exMemSize   <= memSize;
      exMemOp     <= squashing ? 2'd0 : memOp;
      exRd        <= rd;
      exRegWrite  <= ~squashing & aluToReg & ~branch;
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perfOps       <= 32'd0;
      perfRedirects <= 32'd0;
    end else begin
      if (consume && write_valid && perfOps != 32'hFFFF_FFFF) perfOps <= perfOps + 32'd1;
      if (issue_redirect && perfRedirects != 32'hFFFF_FFFF) perfRedirects <= perfRedirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; define EX_PERF_CNT_EN to also exercise the counters.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imm, pc, rs1Val, rs2Val;
  logic        selA;
  logic [1:0]  selB;
  logic [3:0]  aluOp;
  logic [1:0]  memSize, memOp;
  logic [4:0]  rd;
  logic        aluToReg, branch, jal, jalr, memStall;
  logic        stall, redirect, exValid, exRegWrite;
  logic [31:0] redirectPc, exResult, exStoreData;
  logic [1:0]  exMemSize, exMemOp;
  logic [4:0]  exRd;
`ifdef EX_PERF_CNT_EN
  logic [31:0] perfOps, perfRedirects;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage #(.FLUSH_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imm(imm), .pc(pc), .rs1Val(rs1Val), .rs2Val(rs2Val),
    .selA(selA), .selB(selB), .aluOp(aluOp), .memSize(memSize), .memOp(memOp), .rd(rd),
    .aluToReg(aluToReg), .branch(branch), .jal(jal), .jalr(jalr), .memStall(memStall),
    .stall(stall), .redirect(redirect), .redirectPc(redirectPc), .exValid(exValid),
    .exResult(exResult), .exStoreData(exStoreData), .exMemSize(exMemSize), .exMemOp(exMemOp),
    .exRd(exRd),
`ifdef EX_PERF_CNT_EN
    .perfOps(perfOps), .perfRedirects(perfRedirects),
`endif
    .exRegWrite(exRegWrite)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    imm = 0; pc = 0; rs1Val = 0; rs2Val = 0; selA = 0; selB = 0; aluOp = 0;
    memSize = 0; memOp = 0; rd = 0; aluToReg = 0; branch = 0; jal = 0; jalr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_op();
    bubble(); rs1Val = 5; selB = 1; imm = 7; aluOp = 0; rd = 3; aluToReg = 1;
  endtask

  task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sb, input logic [3:0] op, input logic sa,
                         input logic [31:0] exp);
    bubble(); rs1Val = a; rs2Val = b; imm = b; pc = 32'h1000; selA = sa; selB = sb;
    aluOp = op; rd = 5; aluToReg = 1;
    step();
    check(tag, exResult, exp);
  endtask

  initial begin
    bubble();
    memStall = 1'b1;
    reset = 1'b0;
    #12;
    check("rst_stall_hi", {31'd0, stall}, 32'd1);
    check("rst_valid", {31'd0, exValid}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_redirect_pc", redirectPc, 32'd0);
    check("rst_result", exResult, 32'd0);
    check("rst_regwrite", {31'd0, exRegWrite}, 32'd0);
    memStall = 1'b0;
    #1;
    check("rst_stall_lo", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    #1;

    // T1 ADD
    add_op(); memSize = 2; memOp = 1; rs2Val = 32'hCAFE;
    step();
    check("t1_result", exResult, 32'd12);
    check("t1_rd", {27'd0, exRd}, 32'd3);
    check("t1_regwrite", {31'd0, exRegWrite}, 32'd1);
    check("t1_valid", {31'd0, exValid}, 32'd1);
    check("t1_store", exStoreData, 32'hCAFE);
    check("t1_memop", {30'd0, exMemOp}, 32'd1);
    check("t1_memsize", {30'd0, exMemSize}, 32'd2);
    check("t1_no_redirect", {31'd0, redirect}, 32'd0);

    // ALU coverage
    alu_vec("sub", 32'd5, 32'd7, 2'd0, 4'd1, 1'b0, 32'hFFFF_FFFE);
    alu_vec("sll_b5", 32'd1, 32'd33, 2'd0, 4'd2, 1'b0, 32'd2);
    alu_vec("slt", 32'hFFFF_FFFF, 32'd1, 2'd0, 4'd3, 1'b0, 32'd1);
    alu_vec("sltu", 32'hFFFF_FFFF, 32'd1, 2'd0, 4'd4, 1'b0, 32'd0);
    alu_vec("xor", 32'h0000_F0F0, 32'h0000_FF00, 2'd0, 4'd5, 1'b0, 32'h0000_0FF0);
    alu_vec("srl", 32'h8000_0000, 32'd4, 2'd1, 4'd6, 1'b0, 32'h0800_0000);
    alu_vec("sra", 32'h8000_0000, 32'd4, 2'd1, 4'd7, 1'b0, 32'hF800_0000);
    alu_vec("or", 32'h0000_00F0, 32'h0000_000F, 2'd0, 4'd8, 1'b0, 32'h0000_00FF);
    alu_vec("and", 32'h0000_0FF0, 32'h0000_00FF, 2'd0, 4'd9, 1'b0, 32'h0000_00F0);
    alu_vec("passb_4", 32'd9, 32'd9, 2'd2, 4'd10, 1'b0, 32'd4);
    alu_vec("pc_plus_0", 32'd9, 32'd9, 2'd3, 4'd0, 1'b1, 32'h1000);
    alu_vec("ge", 32'hFFFF_FFFF, 32'd1, 2'd0, 4'd13, 1'b0, 32'd0);
    alu_vec("geu", 32'hFFFF_FFFF, 32'd1, 2'd0, 4'd14, 1'b0, 32'd1);
    alu_vec("zero", 32'd5, 32'd7, 2'd0, 4'd15, 1'b0, 32'd0);

    // T2 BEQ taken, then two squashed ops
    bubble(); pc = 32'h100; imm = 32'h20; rs1Val = 9; rs2Val = 9; aluOp = 11; branch = 1;
    step();
    check("t2_redirect", {31'd0, redirect}, 32'd1);
    check("t2_redirect_pc", redirectPc, 32'h120);
    check("t2_valid", {31'd0, exValid}, 32'd1);
    check("t2_br_noreg", {31'd0, exRegWrite}, 32'd0);
    check("t2_br_result", exResult, 32'd1);
    add_op(); memOp = 2;
    step();
    check("t2_sq1_valid", {31'd0, exValid}, 32'd0);
    check("t2_sq1_regwrite", {31'd0, exRegWrite}, 32'd0);
    check("t2_sq1_memop", {30'd0, exMemOp}, 32'd0);
    check("t2_pulse_end", {31'd0, redirect}, 32'd0);
    step();
    check("t2_sq2_valid", {31'd0, exValid}, 32'd0);
    step();
    check("t2_after_valid", {31'd0, exValid}, 32'd1);
    check("t2_after_memop", {30'd0, exMemOp}, 32'd2);

    // T3 JALR
    bubble(); jalr = 1; rs1Val = 32'h203; imm = 0; selB = 1; pc = 32'h40; aluToReg = 1; rd = 1;
    step();
    check("t3_redirect", {31'd0, redirect}, 32'd1);
    check("t3_redirect_pc", redirectPc, 32'h202);
    check("t3_link", exResult, 32'h44);
    check("t3_regwrite", {31'd0, exRegWrite}, 32'd1);
    bubble();
    step();
    step();
    step();
    check("t3_bubble_valid", {31'd0, exValid}, 32'd0);

    // T4 taken branch held by memStall
    add_op();
    step();
    bubble(); pc = 32'h300; imm = 32'h10; rs1Val = 1; rs2Val = 2; aluOp = 12; branch = 1;
    memStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_stall", {31'd0, stall}, 32'd1);
      check("t4_no_redirect", {31'd0, redirect}, 32'd0);
      check("t4_hold_result", exResult, 32'd12);
      check("t4_hold_valid", {31'd0, exValid}, 32'd1);
    end
    memStall = 1'b0;
    step();
    check("t4_redirect", {31'd0, redirect}, 32'd1);
    check("t4_redirect_pc", redirectPc, 32'h310);
    check("t4_br_result", exResult, 32'd1);
    bubble();
    step();
    check("t4_pulse_end", {31'd0, redirect}, 32'd0);
    step();

    // T5 reset during SQUASH with one op left to squash
    bubble(); jal = 1; pc = 32'h500; imm = 8; selB = 1; aluToReg = 1; rd = 1;
    step();
    check("t5_redirect_pc", redirectPc, 32'h508);
    check("t5_link", exResult, 32'h504);
    add_op();
    step();
    check("t5_squashed", {31'd0, exValid}, 32'd0);
    reset = 1'b0;
    #1;
    check("t5_async_result", exResult, 32'd0);
    check("t5_async_rd", {27'd0, exRd}, 32'd0);
    check("t5_async_redirect_pc", redirectPc, 32'd0);
    #2;
    reset = 1'b1;
    step();
    check("t5_first_valid", {31'd0, exValid}, 32'd1);
    check("t5_first_result", exResult, 32'd12);
    check("t5_no_redirect", {31'd0, redirect}, 32'd0);

`ifdef EX_PERF_CNT_EN
    // T6 counters
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_ops", perfOps, 32'd0);
    check("t6_rst_redirects", perfRedirects, 32'd0);
    reset = 1'b1;
    add_op();
    for (int i = 0; i < 3; i++) step();
    bubble(); pc = 32'h100; imm = 32'h20; rs1Val = 9; rs2Val = 9; aluOp = 11; branch = 1;
    step();
    bubble();
    memStall = 1'b1;
    step();
    memStall = 1'b0;
    check("t6_ops", perfOps, 32'd4);
    check("t6_redirects", perfRedirects, 32'd1);
    step();
    step();
    check("t6_ops_squash", perfOps, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
